tw_ram_loader: RTL and testbench

Runtime-loadable twiddle store for one NTT/INTT MDC stage. It accepts a stream of twiddle words from the host or the parameter-load path and writes them into an NTT or INTT RAM bank. The read side has the same port behaviour as the per-stage ROM twiddle source (`intt`, `raddr`, registered `dout`), so it serves as that source's writable counterpart. New moduli then need only a reload, not a re-synthesis.

---
 rtl/tw_pkg.sv | 17 +
 rtl/tw_ram_loader_if.sv | 20 ++
 rtl/tw_ram_bank.sv | 45 ++++
 rtl/tw_ram_loader.sv | 133 +++++++++++++
 tb/tb_tw_ram_loader.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/tw_pkg.sv
// Shared types and helpers for the runtime-loadable twiddle store.
package tw_pkg;

    typedef enum logic [1:0] {
        TW_IDLE = 2'd0,
        TW_LOAD = 2'd1,
        TW_DONE = 2'd2
    } tw_state_e;

    localparam int unsigned TW_BANK_NTT  = 0;
    localparam int unsigned TW_BANK_INTT = 1;

    function automatic int unsigned tw_count(input int unsigned stage);
        return 32'd1 << stage;
    endfunction

endpackage

// File: rtl/tw_ram_loader_if.sv
// Load-control and word-stream handshake between a twiddle source and the loader.
interface tw_ram_loader_if #(
    parameter int unsigned LOGQ = 60
);
    logic            load_start;
    logic            load_intt;
    logic [LOGQ-1:0] s_data;
    logic            s_valid;
    logic            s_ready;

    modport master (
        output load_start, load_intt, s_data, s_valid,
        input  s_ready
    );

    modport slave (
        input  load_start, load_intt, s_data, s_valid,
        output s_ready
    );
endinterface

// File: rtl/tw_ram_bank.sv
// Simple dual-port twiddle RAM: synchronous write, read-first, DELAY_BROM-deep read pipeline.
module tw_ram_bank
    import tw_pkg::*;
#(
    parameter int unsigned LOGQ       = 60,
    parameter int unsigned STAGE      = 0,
    parameter int unsigned DELAY_BROM = 2,
    parameter int unsigned AW         = (STAGE > 0) ? STAGE : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [LOGQ-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [LOGQ-1:0] rdata
);
    localparam int unsigned DEPTH = tw_count(STAGE);

    logic [LOGQ-1:0] mem [DEPTH];
    logic [LOGQ-1:0] pipe_q [DELAY_BROM];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-blocking read of mem alongside the write gives read-first collisions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DELAY_BROM; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= mem[raddr];
            for (int i = 1; i < DELAY_BROM; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign rdata = pipe_q[DELAY_BROM-1];

endmodule

// File: rtl/tw_ram_loader.sv
// Writable twiddle store for one NTT/INTT stage: stream loader FSM plus two RAM banks
// behind a ROM-compatible registered read port.
module tw_ram_loader
    import tw_pkg::*;
#(
    parameter int unsigned LOGQ       = 60,
    parameter int unsigned LOGN       = 12,
    parameter int unsigned STAGE      = 0,
    parameter int unsigned DELAY_BROM = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LOGQ-1:0]   q,
    tw_ram_loader_if.slave    ld,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err,
    output logic [1:0]        bank_valid,
    input  logic              intt,
    input  logic [LOGN-1:0]   raddr,
    output logic [LOGQ-1:0]   dout
);
    localparam int unsigned N_TW = tw_count(STAGE);
    localparam int unsigned AW   = (STAGE > 0) ? STAGE : 1;

    tw_state_e       state_q, state_d;
    logic [AW-1:0]   cnt_q;
    logic            bank_q;
    logic            err_q;
    logic [1:0]      valid_q;
    logic [DELAY_BROM-1:0] intt_pipe_q;
    logic [LOGQ-1:0] dout_q;

    logic            xfer, in_range, last, we_ntt, we_intt;
    logic [AW-1:0]   rd_addr;
    logic [LOGQ-1:0] rd_ntt, rd_intt;
    logic            unused_raddr;

    assign xfer     = (state_q == TW_LOAD) && ld.s_valid;
    assign in_range = ld.s_data < q;
    assign last     = cnt_q == AW'(N_TW - 1);
    assign we_ntt   = xfer && in_range && (bank_q == 1'(TW_BANK_NTT));
    assign we_intt  = xfer && in_range && (bank_q == 1'(TW_BANK_INTT));
    assign rd_addr  = (STAGE == 0) ? '0 : raddr[AW-1:0];
    assign unused_raddr = ^raddr;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TW_IDLE: if (ld.load_start) state_d = TW_LOAD;
            TW_LOAD: if (xfer && last)  state_d = TW_DONE;
            TW_DONE:                    state_d = TW_IDLE;
            default:                    state_d = TW_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TW_IDLE;
            cnt_q   <= '0;
            bank_q  <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 2'b00;
        end else begin
            state_q <= state_d;
            if (state_q == TW_IDLE && ld.load_start) begin
                bank_q                <= ld.load_intt;
                cnt_q                 <= '0;
                err_q                 <= 1'b0;
                valid_q[ld.load_intt] <= 1'b0;
            end
            if (xfer) begin
                cnt_q <= cnt_q + 1'b1;
                if (!in_range) err_q <= 1'b1;
            end
            // A bank is only advertised when every word of its load was in range.
            if (state_q == TW_DONE && !err_q) begin
                valid_q[bank_q] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            intt_pipe_q <= '0;
            dout_q      <= '0;
        end else begin
            intt_pipe_q[0] <= intt;
            for (int i = 1; i < int'(DELAY_BROM); i++) begin
                intt_pipe_q[i] <= intt_pipe_q[i-1];
            end
            dout_q <= intt_pipe_q[DELAY_BROM-1] ? rd_intt : rd_ntt;
        end
    end

    tw_ram_bank #(
        .LOGQ       (LOGQ),
        .STAGE      (STAGE),
        .DELAY_BROM (DELAY_BROM),
        .AW         (AW)
    ) u_bank_ntt (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we_ntt),
        .waddr (cnt_q),
        .wdata (ld.s_data),
        .raddr (rd_addr),
        .rdata (rd_ntt)
    );

    tw_ram_bank #(
        .LOGQ       (LOGQ),
        .STAGE      (STAGE),
        .DELAY_BROM (DELAY_BROM),
        .AW         (AW)
    ) u_bank_intt (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we_intt),
        .waddr (cnt_q),
        .wdata (ld.s_data),
        .raddr (rd_addr),
        .rdata (rd_intt)
    );

    assign ld.s_ready = (state_q == TW_LOAD);
    assign load_busy  = (state_q == TW_LOAD);
    assign load_done  = (state_q == TW_DONE);
    assign load_err   = err_q;
    assign bank_valid = valid_q;
    assign dout       = dout_q;

endmodule

// File: tb/tb_tw_ram_loader.sv
// Directed bench for tw_ram_loader: a STAGE=3 instance for the main flows and a STAGE=0 one.
module tb_tw_ram_loader;
    localparam int LOGQ = 60;
    localparam int LOGN = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [LOGQ-1:0] q = 60'd12289;

    tw_ram_loader_if #(.LOGQ(LOGQ)) lif ();
    tw_ram_loader_if #(.LOGQ(LOGQ)) lif0 ();

    logic            load_busy, load_done, load_err;
    logic [1:0]      bank_valid;
    logic            intt;
    logic [LOGN-1:0] raddr;
    logic [LOGQ-1:0] dout;

    logic            load_busy0, load_done0, load_err0;
    logic [1:0]      bank_valid0;
    logic            intt0;
    logic [LOGN-1:0] raddr0;
    logic [LOGQ-1:0] dout0;

    tw_ram_loader #(.LOGQ(LOGQ), .LOGN(LOGN), .STAGE(3), .DELAY_BROM(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .q(q), .ld(lif),
        .load_busy(load_busy), .load_done(load_done), .load_err(load_err),
        .bank_valid(bank_valid), .intt(intt), .raddr(raddr), .dout(dout)
    );

    tw_ram_loader #(.LOGQ(LOGQ), .LOGN(LOGN), .STAGE(0), .DELAY_BROM(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .q(q), .ld(lif0),
        .load_busy(load_busy0), .load_done(load_done0), .load_err(load_err0),
        .bank_valid(bank_valid0), .intt(intt0), .raddr(raddr0), .dout(dout0)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic            rd_intt;
        logic [LOGN-1:0] rd_addr;
        logic [LOGQ-1:0] exp;
    } rd_vec_t;

    rd_vec_t         vt [16];
    logic [LOGQ-1:0] wbuf [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic read_chk(input bit which, input logic bi, input logic [LOGN-1:0] a,
                            input logic [LOGQ-1:0] e, input string name);
        @(negedge clk);
        if (which) begin intt0 = bi; raddr0 = a; end
        else       begin intt  = bi; raddr  = a; end
        repeat (3) @(negedge clk);
        check(name, which ? dout0 : dout, e);
    endtask

    task automatic do_load(input logic bank, input bit stall, input bit poke,
                           input logic exp_err, input logic [1:0] exp_valid);
        int  i;
        int  cyc;
        logic rdy;
        @(negedge clk);
        lif.load_start = 1'b1; lif.load_intt = bank; lif.s_valid = 1'b0;
        @(negedge clk);
        lif.load_start = 1'b0;
        check("s_ready_rise", lif.s_ready, 1);
        check("busy_in_load", load_busy, 1);
        i = 0; cyc = 0;
        while (i < 8 && cyc < 200) begin
            lif.s_valid = stall ? (cyc % 3 == 2) : 1'b1;
            lif.s_data  = wbuf[i];
            if (poke && cyc == 4) begin lif.load_start = 1'b1; lif.load_intt = 1'b0; end
            rdy = lif.s_ready;
            @(negedge clk);
            lif.load_start = 1'b0;
            if (lif.s_valid && rdy) i++;
            cyc++;
        end
        lif.s_valid = 1'b0;
        check("words_transferred", i, 8);
        if (!stall) check("load_cycles", cyc, 8);
        check("load_done_pulse", load_done, 1);
        check("ready_in_done", lif.s_ready, 0);
        check("load_err", load_err, exp_err);
        @(negedge clk);
        check("done_one_cycle", load_done, 0);
        check("busy_after", load_busy, 0);
        check("bank_valid", bank_valid, exp_valid);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [LOGQ-1:0] cw [8];
        for (int k = 0; k < 8; k++) begin
            vt[2*k]   = '{1'b0, LOGN'(k),     LOGQ'(k + 1)};
            vt[2*k+1] = '{1'b1, LOGN'(7 - k), LOGQ'(107 - k)};
        end

        lif.load_start = 0; lif.load_intt = 0; lif.s_data = '0; lif.s_valid = 0;
        lif0.load_start = 0; lif0.load_intt = 0; lif0.s_data = '0; lif0.s_valid = 0;
        intt = 0; raddr = '0; intt0 = 0; raddr0 = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_s_ready", lif.s_ready, 0);
        check("rst_busy", load_busy, 0);
        check("rst_done", load_done, 0);
        check("rst_err", load_err, 0);
        check("rst_bank_valid", bank_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_dout0", dout0, 0);
        rst_n = 1'b1;

        // Reset mid-load after three transfers
        @(negedge clk);
        lif.load_start = 1'b1; lif.load_intt = 1'b0;
        @(negedge clk);
        lif.load_start = 1'b0; lif.s_valid = 1'b1; lif.s_data = 60'd1;
        @(negedge clk); lif.s_data = 60'd2;
        @(negedge clk); lif.s_data = 60'd3;
        @(negedge clk);
        rst_n = 1'b0; lif.s_valid = 1'b0;
        #1;
        check("midrst_s_ready", lif.s_ready, 0);
        check("midrst_bank_valid", bank_valid, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("midrst_no_done", load_done, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_idle", lif.s_ready, 0);
        check("midrst_no_done_after", load_done, 0);

        // Full NTT load, then INTT load with backpressure and an ignored start
        for (int k = 0; k < 8; k++) wbuf[k] = LOGQ'(k + 1);
        do_load(1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
        for (int k = 0; k < 8; k++) wbuf[k] = LOGQ'(100 + k);
        do_load(1'b1, 1'b1, 1'b1, 1'b0, 2'b11);

        for (int k = 0; k < 16; k++) begin
            read_chk(1'b0, vt[k].rd_intt, vt[k].rd_addr, vt[k].exp, "table_read");
        end

        // Out-of-range word at index 4 is dropped and poisons the bank
        wbuf = '{60'd11, 60'd12, 60'd7, 60'd14, 60'd12289, 60'd16, 60'd17, 60'd18};
        do_load(1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
        read_chk(1'b0, 1'b0, 12'd4, 60'd5, "err_keep_old");
        read_chk(1'b0, 1'b0, 12'd2, 60'd7, "err_neighbor");
        read_chk(1'b0, 1'b0, 12'd7, 60'd18, "err_last");
        read_chk(1'b0, 1'b1, 12'd0, 60'd100, "err_intt_untouched");

        // Read-first collision on address 2
        cw = '{60'd21, 60'd22, 60'd55, 60'd24, 60'd25, 60'd26, 60'd27, 60'd28};
        @(negedge clk);
        lif.load_start = 1'b1; lif.load_intt = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            lif.load_start = 1'b0;
            if (c == 5) check("collision_old", dout, 7);
            if (c == 6) check("collision_new", dout, 55);
            lif.s_valid = 1'b1; lif.s_data = cw[c];
            intt = 1'b0; raddr = (c == 2 || c == 3) ? 12'd2 : 12'd0;
        end
        @(negedge clk);
        lif.s_valid = 1'b0;
        check("coll_done", load_done, 1);
        @(negedge clk);
        check("coll_bank_valid", bank_valid, 2'b11);
        check("coll_err_cleared", load_err, 0);
        read_chk(1'b0, 1'b0, 12'd2, 60'd55, "coll_readback");

        // STAGE = 0 single-word bank
        @(negedge clk);
        lif0.load_start = 1'b1; lif0.load_intt = 1'b0;
        @(negedge clk);
        lif0.load_start = 1'b0;
        check("s0_ready", lif0.s_ready, 1);
        lif0.s_valid = 1'b1; lif0.s_data = 60'd9;
        @(negedge clk);
        lif0.s_valid = 1'b0;
        check("s0_done", load_done0, 1);
        check("s0_ready_done", lif0.s_ready, 0);
        @(negedge clk);
        check("s0_bank_valid", bank_valid0, 2'b01);
        read_chk(1'b1, 1'b0, 12'd0, 60'd9, "s0_read0");
        read_chk(1'b1, 1'b0, 12'd5, 60'd9, "s0_read5");
        read_chk(1'b1, 1'b0, 12'd4095, 60'd9, "s0_read4095");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
